// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the single-byte I2C master.
//   i2c_state_e : transaction sequencer states
//   quarter_e   : position inside one bus slot (q0..q3)
//   WRITE/READ  : values of the R/W bit
//   SLOTS_*     : bus slots per transaction (full, address NACK)
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_AACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_MACK,
    ST_STOP,
    ST_DONE
  } i2c_state_e;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quarter_e;

  localparam logic WRITE = 1'b0;
  localparam logic READ  = 1'b1;

  localparam int unsigned SLOTS_FULL = 20;
  localparam int unsigned SLOTS_NACK = 11;

endpackage

// File: rtl/i2c_clk_div.sv
// i2c_clk_div: quarter-tick generator for the I2C master.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   en_i          : count while high; holds counters at zero when low
//   stall_i       : freezes the counters (SCL held low by a slave)
//   quarter_o     : current quarter of the slot
//   qtick_o       : last cycle of the current quarter, counter advancing
//   slot_end_o    : last cycle of q3 (slot boundary)
module i2c_clk_div
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     en_i,
  input  logic     stall_i,
  output quarter_e quarter_o,
  output logic     qtick_o,
  output logic     slot_end_o
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  quarter_e      qtr_q, qtr_d;
  logic          last_cyc;

  assign last_cyc = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    qtr_d = qtr_q;
    if (!en_i) begin
      cnt_d = '0;
      qtr_d = Q0;
    end else if (!stall_i) begin
      if (last_cyc) begin
        cnt_d = '0;
        qtr_d = quarter_e'(qtr_q + 2'd1);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      qtr_q <= Q0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

  assign quarter_o  = qtr_q;
  assign qtick_o    = en_i && !stall_i && last_cyc;
  assign slot_end_o = qtick_o && (qtr_q == Q3);

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master. One command = START, {addr,rw},
// ACK, one data byte (write or read), STOP; one response per command.
// Ports:
//   clock, reset            : system clock, synchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake (ready = not busy)
//   cmd_addr/cmd_rw/cmd_wdata : target address, 0=write 1=read, write byte
//   rsp_valid               : one-cycle pulse at end of transaction
//   rsp_rdata/rsp_nack      : read byte, any slave NACK seen
//   busy                    : transaction in progress
//   SDA, SCL                : open-drain bus lines (drive 0 or z)
// Option: define I2C_MASTER_CLOCK_STRETCH_EN to honour slave clock stretching.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | bus released, waiting for a command
// START    | START condition slot
// ADDR     | shifting {addr,rw} MSB first
// AACK     | slave address ACK slot
// WDATA    | shifting write byte
// WACK     | slave data ACK slot
// RDATA    | sampling read byte
// MACK     | master NACK slot (SDA released)
// STOP     | STOP condition slot
// DONE     | one cycle, rsp_valid
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  inout  wire        SDA,
  inout  wire        SCL
);

  i2c_state_e state_q, state_d;
  logic [7:0] addr_rw_q, addr_rw_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       nack_q, nack_d;
  logic [2:0] bit_q, bit_d;

  quarter_e   quarter;
  logic       qtick, slot_end, clk_en, stall;
  logic       sda_low, scl_low, sda_in, bit_slot, sample;

  assign sda_in = SDA;
  assign bit_slot = (state_q inside {ST_ADDR, ST_AACK, ST_WDATA, ST_WACK, ST_RDATA, ST_MACK});
  assign sample = qtick && (quarter == Q2);

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
  logic scl_in;
  assign scl_in = SCL;
  // High phase of a bit slot waits until the line actually reads high.
  assign stall  = bit_slot && ((quarter == Q2) || (quarter == Q3)) && !scl_in;
`else
  assign stall  = 1'b0;
`endif

  i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clock      (clock),
    .reset      (reset),
    .en_i       (clk_en),
    .stall_i    (stall),
    .quarter_o  (quarter),
    .qtick_o    (qtick),
    .slot_end_o (slot_end)
  );

  always_comb begin
    state_d   = state_q;
    addr_rw_d = addr_rw_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    nack_d    = nack_q;
    bit_d     = bit_q;
    clk_en    = 1'b1;
    sda_low   = 1'b0;
    scl_low   = bit_slot && ((quarter == Q0) || (quarter == Q1));

    case (state_q)
      ST_IDLE: begin
        clk_en = 1'b0;
        if (cmd_valid) begin
          state_d   = ST_START;
          addr_rw_d = {cmd_addr, cmd_rw};
          wdata_d   = cmd_wdata;
          rdata_d   = 8'h00;
          nack_d    = 1'b0;
          bit_d     = 3'd7;
        end
      end
      ST_START: begin
        sda_low = (quarter == Q2) || (quarter == Q3);
        scl_low = (quarter == Q3);
        if (slot_end) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        sda_low = ~addr_rw_q[bit_q];
        if (slot_end) begin
          if (bit_q == 3'd0) begin
            state_d = ST_AACK;
            bit_d   = 3'd7;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      ST_AACK: begin
        if (sample && sda_in) nack_d = 1'b1;
        // nack_q holds only this slot's sample here: it is cleared on accept.
        if (slot_end) begin
          if (nack_q)                      state_d = ST_STOP;
          else if (addr_rw_q[0] == READ)   state_d = ST_RDATA;
          else                             state_d = ST_WDATA;
        end
      end
      ST_WDATA: begin
        sda_low = ~wdata_q[bit_q];
        if (slot_end) begin
          if (bit_q == 3'd0) begin
            state_d = ST_WACK;
            bit_d   = 3'd7;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      ST_WACK: begin
        if (sample && sda_in) nack_d = 1'b1;
        if (slot_end) state_d = ST_STOP;
      end
      ST_RDATA: begin
        if (sample) rdata_d = {rdata_q[6:0], sda_in};
        if (slot_end) begin
          if (bit_q == 3'd0) begin
            state_d = ST_MACK;
            bit_d   = 3'd7;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      ST_MACK: begin
        if (slot_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        sda_low = (quarter != Q3);
        scl_low = (quarter == Q0);
        if (slot_end) state_d = ST_DONE;
      end
      ST_DONE: begin
        clk_en  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        clk_en  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_rw_q <= 8'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      nack_q    <= 1'b0;
      bit_q     <= 3'd7;
    end else begin
      state_q   <= state_d;
      addr_rw_q <= addr_rw_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      nack_q    <= nack_d;
      bit_q     <= bit_d;
    end
  end

  assign SDA       = sda_low ? 1'b0 : 1'bz;
  assign SCL       = scl_low ? 1'b0 : 1'bz;
  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = ~busy;
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_nack  = nack_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural bus slave at address 0x56, a
// transaction-level reference model feeding scoreboards, and monitors that
// compare responses, latency and bus bytes as the DUT produces them.
module tb_i2c_master_ctrl;
  import i2c_pkg::*;

  localparam int D = 4;
  localparam logic [6:0] SLAVE_ADDR = 7'h56;
`ifdef I2C_MASTER_CLOCK_STRETCH_EN
  localparam bit STRETCH_TEST = 1'b1;
`else
  localparam bit STRETCH_TEST = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  wire        SDA;
  wire        SCL;

  pullup (SDA);
  pullup (SCL);

  logic s_drive = 1'b0;
  int   s_hold  = 0;
  assign SDA = s_drive ? 1'b0 : 1'bz;
  assign SCL = (s_hold > 0) ? 1'b0 : 1'bz;

  i2c_master_ctrl #(.CLK_DIV(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_rw    (cmd_rw),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .SDA       (SDA),
    .SCL       (SCL)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] rdata;
    logic       nack;
    int         lat;
    bit         exact;
  } exp_t;

  exp_t       exp_q[$];
  int         acc_q[$];
  bit         b2b_q[$];
  logic [7:0] byte_q[$];
  logic [7:0] rd_q[$];
  int         rise_q[$];
  bit         prev_hold = 1'b0;
  bit         s_stretch = 1'b0;

  // ---------------- stimulus + reference model ----------------
  task automatic issue(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                       input logic [7:0] rd, input bit hold, input bit track, input bit stretch);
    exp_t e;
    bit   ack;
    int   n;
    ack = (a == SLAVE_ADDR);
    if (track) begin
      e.rdata = (ack && rw == READ) ? rd : 8'h00;
      e.nack  = !ack;
      e.lat   = 1 + 4 * D * (ack ? SLOTS_FULL : SLOTS_NACK);
      e.exact = !stretch;
      exp_q.push_back(e);
      byte_q.push_back({a, rw});
      if (ack && rw == WRITE) byte_q.push_back(wd);
      if (ack && rw == READ)  rd_q.push_back(rd);
      // SCL rising edges: 8 address + ACK (+ 8 data + ACK) + STOP
      rise_q.push_back(ack ? 19 : 10);
    end
    b2b_q.push_back(prev_hold);
    prev_hold = hold;
    s_stretch = stretch;
    cmd_addr  = a;
    cmd_rw    = rw;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 5000) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
  endtask

  // ---------------- response monitor ----------------
  int last_rsp = -100;
  initial forever begin
    @(negedge clock);
    if (reset) begin
      acc_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        acc_q.push_back(cyc);
        if (b2b_q.size() != 0) begin
          if (b2b_q.pop_front()) check("b2b_accept_cycle", cyc, last_rsp + 1);
        end
      end
      if (rsp_valid) begin
        last_rsp = cyc;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_nack", rsp_nack, e.nack);
          if (e.exact) check("rsp_latency", cyc - a, e.lat);
          else         check("stretch_latency_min", (cyc - a >= e.lat + 20), 1);
        end
      end
    end
  end

  // ---------------- behavioural bus slave + bus monitor ----------------
  logic       sda_n, scl_n, sda_p = 1'b1, scl_p = 1'b1;
  bit         s_active = 0, s_in_ack = 0, s_match = 0, s_rw = 0, s_reading = 0;
  int         s_cnt = 0, s_byte = 0, s_rises = 0, stop_cyc = 0;
  bit         have_stop = 0;
  logic [7:0] s_shift = '0, s_rd = '0;

  initial forever begin
    @(negedge clock);
    sda_n = (SDA !== 1'b0);
    scl_n = (SCL !== 1'b0);
    if (s_hold > 0) s_hold--;
    if (reset) begin
      s_active = 0; s_in_ack = 0; s_reading = 0; s_drive = 1'b0; s_hold = 0;
    end else if (scl_n && scl_p && sda_p && !sda_n) begin
      if (have_stop) check("bus_idle_gap", (cyc - stop_cyc >= 2), 1);
      s_active = 1; s_cnt = 0; s_byte = 0; s_in_ack = 0; s_match = 0;
      s_reading = 0; s_rises = 0; s_drive = 1'b0;
    end else if (scl_n && scl_p && !sda_p && sda_n) begin
      if (s_active && rise_q.size() != 0) check("scl_rises", s_rises, rise_q.pop_front());
      s_active = 0; s_drive = 1'b0; stop_cyc = cyc; have_stop = 1;
    end else if (s_active && !scl_p && scl_n) begin
      s_rises++;
      if (s_in_ack) begin
        if (s_byte == 1 && s_rw) check("mack_sda_high", sda_n, 1'b1);
      end else if (s_cnt < 8) begin
        s_shift = {s_shift[6:0], sda_n};
        s_cnt++;
      end
    end else if (s_active && scl_p && !scl_n) begin
      if (s_in_ack) begin
        s_in_ack = 0; s_cnt = 0; s_byte++;
        if (s_byte == 1 && s_rw && s_match) begin
          s_reading = 1;
          s_rd = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hFF;
          s_drive = ~s_rd[7];
        end else begin
          s_drive = 1'b0;
        end
      end else if (s_cnt == 8) begin
        s_in_ack = 1; s_reading = 0;
        if (s_byte == 0) begin
          if (byte_q.size() != 0) check("bus_addr_byte", s_shift, byte_q.pop_front());
          else check("bus_byte_unexpected", 32'd1, 32'd0);
          s_match = (s_shift[7:1] == SLAVE_ADDR);
          s_rw    = s_shift[0];
          s_drive = s_match;
          if (s_stretch) begin
            s_hold = 2 * D + 20;
            s_stretch = 0;
          end
        end else if (!s_rw) begin
          if (byte_q.size() != 0) check("bus_data_byte", s_shift, byte_q.pop_front());
          else check("bus_byte_unexpected", 32'd1, 32'd0);
          s_drive = s_match;
        end else begin
          s_drive = 1'b0;
        end
      end else if (s_reading) begin
        s_drive = ~s_rd[7 - s_cnt];
      end
    end
    sda_p = sda_n;
    scl_p = scl_n;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [6:0] a;
    logic       rw;
    logic [7:0] wd, rd;
    bit         hold;

    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("idle_sda", SDA, 1'b1);
    check("idle_scl", SCL, 1'b1);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, 8'h00);
    check("reset_rsp_nack", rsp_nack, 1'b0);
    @(posedge clock);
    #1;

    issue(7'h56, WRITE, 8'h37, 8'h00, 0, 1, STRETCH_TEST);
    wait_idle();
    issue(7'h56, READ, 8'h00, 8'hA5, 0, 1, 0);
    wait_idle();
    issue(7'h12, WRITE, 8'h37, 8'h00, 0, 1, 0);
    wait_idle();
    issue(7'h56, WRITE, 8'h37, 8'h00, 1, 1, 0);
    issue(7'h56, READ, 8'h00, 8'hA5, 0, 1, 0);
    wait_idle();

    for (int i = 0; i < 14; i++) begin
      a = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) a = SLAVE_ADDR;
      else if (a == SLAVE_ADDR) a = 7'h12;
      rw   = 1'($urandom_range(0, 1));
      wd   = 8'($urandom_range(0, 255));
      rd   = 8'($urandom_range(0, 255));
      hold = ($urandom_range(0, 2) == 0) && (i != 13);
      issue(a, rw, wd, rd, hold, 1, 0);
      if (!hold) repeat ($urandom_range(0, 5)) @(posedge clock);
      #1;
    end
    wait_idle();

    // Abort mid address bit 3: START slot + 4 address slots, then D into bit 3.
    issue(7'h56, READ, 8'h00, 8'h00, 0, 0, 0);
    repeat (21 * D) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_sda", SDA, 1'b1);
    check("abort_scl", SCL, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_cmd_ready", cmd_ready, 1'b1);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_rsp_nack", rsp_nack, 1'b0);
    reset = 1'b0;
    prev_hold = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    issue(7'h56, READ, 8'h00, 8'h3C, 0, 1, 0);
    wait_idle();

    check("leftover_exp", exp_q.size(), 0);
    check("leftover_bytes", byte_q.size(), 0);
    check("leftover_rises", rise_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
